imu_int_generator: RTL

IMU_INT_GENERATOR -- requirements
Module: imu_int_generator

---
 rtl/imu_sync_pkg.sv | 22 ++
 rtl/imu_int_generator.sv | 132 +++++++++++++
 2 files changed

// File: rtl/imu_sync_pkg.sv
// Shared definitions for the IMU interrupt generator and the IMU synchroniser.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   imu_state_t         interrupt generator FSM state
//   PERIOD_W_DEF        default period / down-counter width
//   PULSE_W_DEF         default pulse-width configuration width
//   CNT_W_DEF           default sample counter width (matches samples_per_frame)
package imu_sync_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } imu_state_t;

  localparam int unsigned PERIOD_W_DEF = 32;
  localparam int unsigned PULSE_W_DEF  = 16;
  localparam int unsigned CNT_W_DEF    = 8;

endpackage

// File: rtl/imu_int_generator.sv
// Emulated IMU data-ready interrupt: periodic pulse train with clamped period/pulse config.
// Latency: imu_int rises 1 clk after enable is first sampled high (or after rst falls with enable high).
// Backpressure: none; enable is a level request, dropping it lets the current period finish first.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   enable            level request for continuous interrupt generation
//   period_cycles     clk cycles between consecutive imu_int rising edges (clamped to >= 2)
//   pulse_cycles      clk cycles imu_int is high per period (clamped to 1 .. period-1)
//   imu_int           interrupt output, registered
//   sample_count      pulses issued since enable was last asserted from idle (wraps)
//   period_done       one-cycle strobe on the last cycle of every period
//   busy              high whenever a period is in progress
module imu_int_generator
  import imu_sync_pkg::*;
#(
  parameter int unsigned PERIOD_W = PERIOD_W_DEF,
  parameter int unsigned PULSE_W  = PULSE_W_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period_cycles,
  input  logic [PULSE_W-1:0]  pulse_cycles,
  output logic                imu_int,
  output logic [CNT_W-1:0]    sample_count,
  output logic                period_done,
  output logic                busy
);

  imu_state_t          state;
  imu_state_t          state_nxt;
  logic                load;

  // Down-counter holds the number of cycles remaining in the current period
  // after this one; it is loaded with period_eff-1 on entry to PULSE.
  logic [PERIOD_W-1:0] cnt;
  logic [PERIOD_W-1:0] period_sh;
  logic [PERIOD_W-1:0] pulse_sh;
  logic [PERIOD_W-1:0] gap_len;

  logic [PERIOD_W-1:0] period_eff;
  logic [PERIOD_W-1:0] pulse_raw;
  logic [PERIOD_W-1:0] pulse_eff;

  // Clamp so every period has at least one high and one low cycle.
  // period_eff >= 2, so period_eff-1 never underflows; at the maximum period
  // the counter load is all-ones minus one and nothing overflows.
  always_comb begin
    period_eff = period_cycles;
    if (period_cycles < PERIOD_W'(2)) begin
      period_eff = PERIOD_W'(2);
    end
    pulse_raw = PERIOD_W'(pulse_cycles);
    if (pulse_raw == '0) begin
      pulse_raw = PERIOD_W'(1);
    end
    pulse_eff = pulse_raw;
    if (pulse_raw >= period_eff) begin
      pulse_eff = period_eff - PERIOD_W'(1);
    end
  end

  // The last PULSE cycle is the one where the remaining count equals the gap length.
  assign gap_len = period_sh - pulse_sh;

  always_comb begin
    state_nxt   = state;
    load        = 1'b0;
    period_done = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_nxt = PULSE;
          load      = 1'b1;
        end
      end
      PULSE: begin
        if (cnt == gap_len) begin
          state_nxt = GAP;
        end
      end
      GAP: begin
        if (cnt == '0) begin
          period_done = 1'b1;
          if (enable) begin
            state_nxt = PULSE;
            load      = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      imu_int      <= 1'b0;
      sample_count <= '0;
      cnt          <= '0;
      period_sh    <= '0;
      pulse_sh     <= '0;
    end else begin
      state   <= state_nxt;
      imu_int <= (state_nxt == PULSE);

      if (load) begin
        period_sh <= period_eff;
        pulse_sh  <= pulse_eff;
        cnt       <= period_eff - PERIOD_W'(1);
      end else if (state != IDLE && cnt != '0) begin
        cnt <= cnt - PERIOD_W'(1);
      end

      // Starting from idle clears the count and counts the first pulse in one step.
      if (load && state == IDLE) begin
        sample_count <= CNT_W'(1);
      end else if (load) begin
        sample_count <= sample_count + CNT_W'(1);
      end
    end
  end

endmodule
